// File: rtl/spi_flash_sequencer.sv
// Command sequencer above spi_interface: loads opcode/address/payload into the TX FIFO,
// starts transfers, and for PROGRAM/ERASE wraps them in WREN plus RDSR status polling.
module spi_flash_sequencer #(
    parameter int unsigned DATA         = 8,
    parameter int unsigned MAX_BYTES    = 256,
    parameter int unsigned BUSY_TIMEOUT = 1024,
    parameter int unsigned POLL_LIMIT   = 65535,
    parameter logic [7:0]  OPC_WREN     = 8'h06,
    parameter logic [7:0]  OPC_RDSR     = 8'h05
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_kind,
    input  logic [7:0]      cmd_opcode,
    input  logic [23:0]     cmd_addr,
    input  logic [15:0]     cmd_nbytes,
    input  logic [DATA-1:0] pl_data,
    input  logic            pl_valid,
    output logic            pl_ready,
    output logic            done,
    output logic [1:0]      err,
    output logic [15:0]     len,
    output logic            op,
    output logic            work,
    input  logic            busy,
    output logic [DATA-1:0] tx_wdata,
    output logic            tx_wr,
    input  logic            tx_full,
    input  logic [DATA-1:0] rx_rdata,
    output logic            rx_rd,
    input  logic            rx_empty
);

    localparam logic [1:0] KRead  = 2'd0;
    localparam logic [1:0] KProg  = 2'd1;
    localparam logic [1:0] KErase = 2'd2;
    localparam logic [1:0] KRegRd = 2'd3;

    localparam int unsigned TW = $clog2(BUSY_TIMEOUT + 1);
    localparam int unsigned PW = $clog2(POLL_LIMIT + 1);

    typedef enum logic [3:0] {
        StIdle, StLoadWren, StLoad, StStart, StWaitHi, StWaitLo, StPollLoad, StPollRd, StDone
    } state_e;

    typedef enum logic [1:0] {PhWren, PhMain, PhPoll} phase_e;

    state_e        state_q, state_d;
    phase_e        phase_q, phase_d;
    logic [1:0]    kind_q;
    logic [7:0]    opcode_q;
    logic [23:0]   addr_q;
    logic [15:0]   nbytes_q;
    logic [15:0]   byte_q, byte_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [PW-1:0] poll_q, poll_d;
    logic [15:0]   len_q, len_d;
    logic          op_q, op_d;
    logic [1:0]    err_q, err_d;
    logic          cmd_ready_q;
    logic          latch;
    logic          push;
    logic [7:0]    hdr_byte;
    logic [15:0]   hdr_last;
    logic [15:0]   total_last;
    logic          unused_rx;

    // Only the WIP bit of the status byte matters.
    assign unused_rx = ^rx_rdata[DATA-1:1];

    function automatic logic [15:0] main_len(input logic [1:0] k, input logic [15:0] n);
        logic [15:0] bits;
        bits = {n[12:0], 3'b000};
        unique case (k)
            KErase:  main_len = 16'd32;
            KRegRd:  main_len = 16'd8 + bits;
            default: main_len = 16'd32 + bits;
        endcase
    endfunction

    function automatic logic len_ok(input logic [1:0] k, input logic [15:0] n);
        unique case (k)
            KErase:  len_ok = 1'b1;
            KRegRd:  len_ok = ({16'd0, n} <= MAX_BYTES);
            default: len_ok = (n != 16'd0) && ({16'd0, n} <= MAX_BYTES);
        endcase
    endfunction

    assign cmd_ready = cmd_ready_q;
    assign len       = len_q;
    assign op        = op_q;
    assign err       = err_q;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        byte_d     = byte_q;
        tmo_d      = tmo_q;
        poll_d     = poll_q;
        len_d      = len_q;
        op_d       = op_q;
        err_d      = err_q;
        latch      = 1'b0;
        push       = 1'b0;
        hdr_byte   = 8'h00;
        tx_wr      = 1'b0;
        tx_wdata   = '0;
        pl_ready   = 1'b0;
        work       = 1'b0;
        rx_rd      = 1'b0;
        done       = 1'b0;
        // Header is opcode only for REG_READ, opcode plus 3 address bytes otherwise.
        hdr_last   = (kind_q == KRegRd) ? 16'd0 : 16'd3;
        total_last = hdr_last + ((kind_q == KProg) ? nbytes_q : 16'd0);

        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready_q) begin
                    latch  = 1'b1;
                    poll_d = '0;
                    byte_d = '0;
                    err_d  = 2'd0;
                    if (!len_ok(cmd_kind, cmd_nbytes)) begin
                        state_d = StDone;
                        err_d   = 2'd1;
                    end else if (cmd_kind == KProg || cmd_kind == KErase) begin
                        state_d = StLoadWren;
                        len_d   = 16'd8;
                        op_d    = 1'b1;
                    end else begin
                        state_d = StLoad;
                        len_d   = main_len(cmd_kind, cmd_nbytes);
                        op_d    = 1'b0;
                    end
                end
            end
            StLoadWren: begin
                tx_wdata = DATA'(OPC_WREN);
                if (!tx_full) begin
                    tx_wr   = 1'b1;
                    phase_d = PhWren;
                    state_d = StStart;
                end
            end
            StLoad: begin
                if (byte_q <= hdr_last) begin
                    unique case (byte_q[1:0])
                        2'd0: hdr_byte = opcode_q;
                        2'd1: hdr_byte = addr_q[23:16];
                        2'd2: hdr_byte = addr_q[15:8];
                        2'd3: hdr_byte = addr_q[7:0];
                    endcase
                    tx_wdata = DATA'(hdr_byte);
                    push     = !tx_full;
                end else begin
                    tx_wdata = pl_data;
                    pl_ready = !tx_full;
                    push     = pl_valid && !tx_full;
                end
                tx_wr = push;
                if (push) begin
                    if (byte_q == total_last) begin
                        byte_d  = '0;
                        phase_d = PhMain;
                        state_d = StStart;
                    end else begin
                        byte_d = byte_q + 16'd1;
                    end
                end
            end
            StStart: begin
                if (!busy) begin
                    work    = 1'b1;
                    tmo_d   = TW'(1);
                    state_d = StWaitHi;
                end
            end
            StWaitHi: begin
                // tmo_q counts cycles since the work pulse.
                if (busy) begin
                    state_d = StWaitLo;
                end else if (tmo_q == TW'(BUSY_TIMEOUT - 1)) begin
                    state_d = StDone;
                    err_d   = 2'd3;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            StWaitLo: begin
                if (!busy) begin
                    unique case (phase_q)
                        PhWren: begin
                            state_d = StLoad;
                            byte_d  = '0;
                            len_d   = main_len(kind_q, nbytes_q);
                            op_d    = 1'b1;
                        end
                        PhMain: begin
                            if (kind_q == KRead || kind_q == KRegRd) begin
                                state_d = StDone;
                                err_d   = 2'd0;
                            end else begin
                                state_d = StPollLoad;
                                len_d   = 16'd16;
                                op_d    = 1'b0;
                            end
                        end
                        default: state_d = StPollRd;
                    endcase
                end
            end
            StPollLoad: begin
                tx_wdata = DATA'(OPC_RDSR);
                if (!tx_full) begin
                    tx_wr   = 1'b1;
                    phase_d = PhPoll;
                    state_d = StStart;
                end
            end
            StPollRd: begin
                if (!rx_empty) begin
                    rx_rd = 1'b1;
                    if (!rx_rdata[0]) begin
                        state_d = StDone;
                        err_d   = 2'd0;
                    end else if (poll_q == PW'(POLL_LIMIT - 1)) begin
                        state_d = StDone;
                        err_d   = 2'd2;
                    end else begin
                        poll_d  = poll_q + PW'(1);
                        state_d = StPollLoad;
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                err_d   = 2'd0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            phase_q     <= PhWren;
            kind_q      <= KRead;
            opcode_q    <= '0;
            addr_q      <= '0;
            nbytes_q    <= '0;
            byte_q      <= '0;
            tmo_q       <= '0;
            poll_q      <= '0;
            len_q       <= '0;
            op_q        <= 1'b0;
            err_q       <= 2'd0;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            byte_q      <= byte_d;
            tmo_q       <= tmo_d;
            poll_q      <= poll_d;
            len_q       <= len_d;
            op_q        <= op_d;
            err_q       <= err_d;
            cmd_ready_q <= (state_d == StIdle);
            if (latch) begin
                kind_q   <= cmd_kind;
                opcode_q <= cmd_opcode;
                addr_q   <= cmd_addr;
                nbytes_q <= cmd_nbytes;
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_sequencer.sv
// Directed bench for spi_flash_sequencer with a small spi_interface/flash response model.
module tb_spi_flash_sequencer;

    localparam int unsigned DATA = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [1:0]      cmd_kind = 2'd0;
    logic [7:0]      cmd_opcode = 8'h00;
    logic [23:0]     cmd_addr = 24'h0;
    logic [15:0]     cmd_nbytes = 16'h0;
    logic [DATA-1:0] pl_data = '0;
    logic            pl_valid = 1'b0;
    logic            pl_ready;
    logic            done;
    logic [1:0]      err;
    logic [15:0]     len;
    logic            op;
    logic            work;
    logic            busy = 1'b0;
    logic [DATA-1:0] tx_wdata;
    logic            tx_wr;
    logic            tx_full = 1'b0;
    logic [DATA-1:0] rx_rdata = '0;
    logic            rx_rd;
    logic            rx_empty = 1'b1;

    spi_flash_sequencer #(
        .DATA        (DATA),
        .MAX_BYTES   (256),
        .BUSY_TIMEOUT(16),
        .POLL_LIMIT  (4),
        .OPC_WREN    (8'h06),
        .OPC_RDSR    (8'h05)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_kind  (cmd_kind),
        .cmd_opcode(cmd_opcode),
        .cmd_addr  (cmd_addr),
        .cmd_nbytes(cmd_nbytes),
        .pl_data   (pl_data),
        .pl_valid  (pl_valid),
        .pl_ready  (pl_ready),
        .done      (done),
        .err       (err),
        .len       (len),
        .op        (op),
        .work      (work),
        .busy      (busy),
        .tx_wdata  (tx_wdata),
        .tx_wr     (tx_wr),
        .tx_full   (tx_full),
        .rx_rdata  (rx_rdata),
        .rx_rd     (rx_rd),
        .rx_empty  (rx_empty)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Payload bytes and flash status bytes, consumed in order across the whole run.
    logic [7:0] pl_mem [3] = '{8'hAA, 8'h55, 8'h77};
    logic [7:0] stat_mem [8] = '{8'h01, 8'h01, 8'h00, 8'h03, 8'h03, 8'h03, 8'h03, 8'h00};

    bit          dead = 1'b0;
    bit          toggle = 1'b0;
    int          cyc = 0;
    int          acc_cyc = 0, done_cyc = 0, work_cyc = 0;
    int          work_cnt = 0, done_cnt = 0, rx_rd_cnt = 0, full_viol = 0, stab_viol = 0;
    int          pl_idx = 0, stat_idx = 0, bcnt = 0;
    logic [1:0]  last_err = 2'd0;
    logic [16:0] prev_oplen = '0;
    logic [16:0] blen = '0;
    logic [7:0]  tx_log [$];
    logic [16:0] oplen_log [$];
    logic [7:0]  rx_q [$];

    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) acc_cyc = cyc;
        if (tx_wr) begin
            if (tx_full) full_viol++;
            else tx_log.push_back(tx_wdata);
        end
        if (work) begin
            work_cnt++;
            work_cyc = cyc;
            oplen_log.push_back({op, len});
            if (prev_oplen != {op, len}) stab_viol++;
        end
        prev_oplen = {op, len};
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            last_err = err;
        end
        if (rx_rd) begin
            rx_rd_cnt++;
            if (rx_q.size() > 0) void'(rx_q.pop_front());
        end
        if (pl_valid && pl_ready) pl_idx++;
        if (work && !dead) begin
            busy <= 1'b1;
            bcnt = 3;
            blen = {op, len};
        end else if (busy) begin
            if (bcnt == 0) begin
                busy <= 1'b0;
                if (blen == 17'h0_0010) begin
                    rx_q.push_back(stat_idx < 8 ? stat_mem[stat_idx] : 8'h00);
                    stat_idx++;
                end
            end else begin
                bcnt--;
            end
        end
        rx_empty <= (rx_q.size() == 0);
        rx_rdata <= (rx_q.size() > 0) ? rx_q[0] : 8'h00;
        pl_valid <= (pl_idx < 3);
        pl_data  <= (pl_idx < 3) ? pl_mem[pl_idx] : 8'h00;
        tx_full  <= toggle && (cyc % 3 != 0);
        cyc++;
    end

    int tx_base = 0, ol_base = 0, w_base = 0, d_base = 0, r_base = 0;
    logic [7:0]  exp_tx [$];
    logic [16:0] exp_ol [$];

    task automatic mark();
        tx_base = tx_log.size();
        ol_base = oplen_log.size();
        w_base  = work_cnt;
        d_base  = done_cnt;
        r_base  = rx_rd_cnt;
    endtask

    task automatic issue(input string tag, input logic [1:0] k, input logic [7:0] opc,
                         input logic [23:0] a, input logic [15:0] n);
        logic seen;
        @(negedge clk);
        cmd_kind = k; cmd_opcode = opc; cmd_addr = a; cmd_nbytes = n; cmd_valid = 1'b1;
        seen = cmd_ready;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = cmd_ready;
        end
        check({tag, "_ready"}, seen, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && done_cnt == d_base; i++) @(negedge clk);
        check({tag, "_done_cnt"}, done_cnt - d_base, 1);
    endtask

    task automatic check_tx(input string tag);
        int n;
        n = tx_log.size() - tx_base;
        check({tag, "_tx_count"}, n, exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < n; i++)
            check($sformatf("%s_tx%0d", tag, i), tx_log[tx_base + i], exp_tx[i]);
    endtask

    task automatic check_ol(input string tag);
        int n;
        n = oplen_log.size() - ol_base;
        check({tag, "_work_count"}, n, exp_ol.size());
        for (int i = 0; i < exp_ol.size() && i < n; i++)
            check($sformatf("%s_oplen%0d", tag, i), oplen_log[ol_base + i], exp_ol[i]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, {cmd_ready, done, work, tx_wr, op, rx_rd, pl_ready, err}, 0);
        check({tag, "_len"}, len, 0);
        check({tag, "_wdata"}, tx_wdata, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b1;
        @(negedge clk);
        check("rst_ready_after", cmd_ready, 1);

        // READ 0x03 @0x123456, 4 bytes
        mark();
        issue("t1", 2'd0, 8'h03, 24'h123456, 16'd4);
        wait_done("t1", 200);
        check("t1_err", last_err, 0);
        exp_tx = '{8'h03, 8'h12, 8'h34, 8'h56};
        check_tx("t1");
        exp_ol = '{17'h0_0040};
        check_ol("t1");
        check("t1_rx_rd", rx_rd_cnt - r_base, 0);
        @(negedge clk);
        check("t1_ready_back", cmd_ready, 1);

        // PROGRAM 0x02 @0x000100, payload AA 55, status 01,01,00
        mark();
        issue("t2", 2'd1, 8'h02, 24'h000100, 16'd2);
        wait_done("t2", 400);
        check("t2_err", last_err, 0);
        exp_tx = '{8'h06, 8'h02, 8'h00, 8'h01, 8'h00, 8'hAA, 8'h55, 8'h05, 8'h05, 8'h05};
        check_tx("t2");
        exp_ol = '{17'h1_0008, 17'h1_0030, 17'h0_0010, 17'h0_0010, 17'h0_0010};
        check_ol("t2");
        check("t2_rx_rd", rx_rd_cnt - r_base, 3);

        // ERASE 0x20 with flash stuck busy: poll limit reached
        mark();
        issue("t3", 2'd2, 8'h20, 24'h010000, 16'd0);
        wait_done("t3", 600);
        check("t3_err", last_err, 2);
        exp_tx = '{8'h06, 8'h20, 8'h01, 8'h00, 8'h00, 8'h05, 8'h05, 8'h05, 8'h05};
        check_tx("t3");
        check("t3_rx_rd", rx_rd_cnt - r_base, 4);
        check("t3_work", work_cnt - w_base, 6);

        // Length rejects
        mark();
        issue("t4a", 2'd0, 8'h03, 24'h0, 16'd0);
        wait_done("t4a", 20);
        check("t4a_err", last_err, 1);
        check("t4a_latency", done_cyc - acc_cyc, 1);
        mark();
        issue("t4b", 2'd0, 8'h03, 24'h0, 16'd257);
        wait_done("t4b", 20);
        check("t4b_err", last_err, 1);
        check("t4b_latency", done_cyc - acc_cyc, 1);
        check("t4b_no_tx", tx_log.size() - tx_base, 0);
        check("t4b_no_work", work_cnt - w_base, 0);

        // REG_READ 0x9F, 3 bytes: opcode only, len = 8 + 24
        mark();
        issue("t4c", 2'd3, 8'h9F, 24'hFFFFFF, 16'd3);
        wait_done("t4c", 200);
        check("t4c_err", last_err, 0);
        exp_tx = '{8'h9F};
        check_tx("t4c");
        exp_ol = '{17'h0_0020};
        check_ol("t4c");

        // Busy never rises; tx_full toggling during LOAD
        mark();
        dead = 1'b1;
        toggle = 1'b1;
        issue("t5", 2'd0, 8'h0B, 24'hA1B2C3, 16'd1);
        wait_done("t5", 200);
        check("t5_err", last_err, 3);
        check("t5_timeout_cycles", done_cyc - work_cyc, 16);
        check("t5_work", work_cnt - w_base, 1);
        exp_tx = '{8'h0B, 8'hA1, 8'hB2, 8'hC3};
        check_tx("t5");
        dead = 1'b0;
        toggle = 1'b0;

        // Reset during WAIT_LO of a PROGRAM main transfer, then a clean ERASE
        mark();
        issue("t6", 2'd1, 8'h02, 24'h000000, 16'd1);
        for (int i = 0; i < 200 && work_cnt - w_base < 2; i++) @(negedge clk);
        check("t6_main_started", work_cnt - w_base, 2);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("t6_rst");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_no_done", done_cnt - d_base, 0);
        mark();
        issue("t6e", 2'd2, 8'hD8, 24'h00ABCD, 16'd5);
        wait_done("t6e", 400);
        check("t6e_err", last_err, 0);
        exp_tx = '{8'h06, 8'hD8, 8'h00, 8'hAB, 8'hCD, 8'h05};
        check_tx("t6e");
        exp_ol = '{17'h1_0008, 17'h1_0020, 17'h0_0010};
        check_ol("t6e");

        check("push_while_full", full_viol, 0);
        check("len_op_stable_before_work", stab_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
